// File: rtl/zcip_tile_ctrl.sv
// rtl/zcip_tile_ctrl.sv - tile sequencer for a ZCIP lane array: clear, run to completion/timeout, report
module zcip_tile_ctrl #(
    parameter int LANES = 128,
    parameter int IDX_W = 7,
    parameter int TMO_W = 8
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   tile_valid,
    output logic                   tile_ready,
    input  logic [LANES*IDX_W-1:0] tile_idx,
    input  logic [LANES-1:0]       tile_mask,
    input  logic [TMO_W-1:0]       cfg_timeout,
    output logic                   arr_clr,
    output logic [LANES*IDX_W-1:0] arr_index_vector,
    input  logic [LANES-1:0]       arr_valid,
    input  logic [LANES-1:0]       arr_done,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [15:0]            res_cycles,
    output logic [15:0]            res_vcnt,
    output logic                   res_timeout,
    output logic                   busy
);

    typedef enum logic [1:0] {S_IDLE, S_CLR, S_RUN, S_RESULT} state_t;

    state_t             state;
    logic [LANES-1:0]   mask_q;
    logic [LANES-1:0]   sticky;
    logic [TMO_W-1:0]   tmo_q;
    logic [15:0]        cyc_cnt;
    logic [15:0]        vld_cnt;

    logic [LANES-1:0]   vld_m;
    logic [31:0]        pop;
    logic [31:0]        vld_sum;
    logic [15:0]        cyc_next;
    logic [15:0]        vld_next;
    logic               complete;
    logic               timeout_hit;

    // Next-cycle counter values include the current RUN cycle, so results reflect the final cycle too.
    always_comb begin
        vld_m = arr_valid & mask_q;
        pop   = '0;
        for (int i = 0; i < LANES; i++) begin
            pop = pop + {{31{1'b0}}, vld_m[i]};
        end
        vld_sum     = {16'b0, vld_cnt} + pop;
        vld_next    = (vld_sum > 32'h0000_FFFF) ? 16'hFFFF : vld_sum[15:0];
        cyc_next    = (cyc_cnt == 16'hFFFF) ? cyc_cnt : cyc_cnt + 16'd1;
        complete    = ((sticky | arr_done) & mask_q) == mask_q;
        timeout_hit = (tmo_q != '0) && (32'(tmo_q) == {16'b0, cyc_next}) && !complete;
    end

    assign tile_ready = (state == S_IDLE) && !rstn;
    assign arr_clr    = rstn || (state == S_CLR);
    assign res_valid  = (state == S_RESULT);
    assign busy       = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (rstn) begin
            state            <= S_IDLE;
            mask_q           <= '0;
            sticky           <= '0;
            tmo_q            <= '0;
            cyc_cnt          <= '0;
            vld_cnt          <= '0;
            arr_index_vector <= '0;
            res_cycles       <= '0;
            res_vcnt         <= '0;
            res_timeout      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (tile_valid) begin
                        arr_index_vector <= tile_idx;
                        mask_q           <= tile_mask;
                        tmo_q            <= cfg_timeout;
                        state            <= S_CLR;
                    end
                end
                S_CLR: begin
                    cyc_cnt <= '0;
                    vld_cnt <= '0;
                    sticky  <= '0;
                    if (mask_q == '0) begin
                        res_cycles  <= '0;
                        res_vcnt    <= '0;
                        res_timeout <= 1'b0;
                        state       <= S_RESULT;
                    end else begin
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    cyc_cnt <= cyc_next;
                    vld_cnt <= vld_next;
                    sticky  <= sticky | (arr_done & mask_q);
                    if (complete || timeout_hit) begin
                        res_cycles  <= cyc_next;
                        res_vcnt    <= vld_next;
                        res_timeout <= timeout_hit;
                        state       <= S_RESULT;
                    end
                end
                S_RESULT: begin
                    if (res_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_zcip_tile_ctrl.sv
// tb/tb_zcip_tile_ctrl.sv - scoreboard bench for zcip_tile_ctrl with a simple lane-array stimulus model
module tb_zcip_tile_ctrl;

    localparam int LANES = 128;
    localparam int IDX_W = 7;
    localparam int TMO_W = 8;

    typedef struct {
        logic [LANES*IDX_W-1:0] idx;
        logic [LANES-1:0]       mask;
        logic [LANES-1:0]       va;
        logic [LANES-1:0]       da;
        logic [LANES-1:0]       db;
        logic [TMO_W-1:0]       tmo;
        int                     ca;
        int                     cb;
    } tile_t;

    typedef struct {
        logic [15:0] cyc;
        logic [15:0] vcnt;
        logic        to;
        int          lat;
    } res_t;

    logic                   clk = 1'b0;
    logic                   rstn;
    logic                   tile_valid;
    logic                   tile_ready;
    logic [LANES*IDX_W-1:0] tile_idx;
    logic [LANES-1:0]       tile_mask;
    logic [TMO_W-1:0]       cfg_timeout;
    logic                   arr_clr;
    logic [LANES*IDX_W-1:0] arr_index_vector;
    logic [LANES-1:0]       arr_valid;
    logic [LANES-1:0]       arr_done;
    logic                   res_valid;
    logic                   res_ready;
    logic [15:0]            res_cycles;
    logic [15:0]            res_vcnt;
    logic                   res_timeout;
    logic                   busy;

    int    n_checks = 0;
    int    n_errors = 0;
    res_t  exp_q[$];
    tile_t cur;
    int    ac_cyc;

    zcip_tile_ctrl #(.LANES(LANES), .IDX_W(IDX_W), .TMO_W(TMO_W)) dut (
        .clk(clk), .rstn(rstn),
        .tile_valid(tile_valid), .tile_ready(tile_ready),
        .tile_idx(tile_idx), .tile_mask(tile_mask), .cfg_timeout(cfg_timeout),
        .arr_clr(arr_clr), .arr_index_vector(arr_index_vector),
        .arr_valid(arr_valid), .arr_done(arr_done),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_cycles(res_cycles), .res_vcnt(res_vcnt), .res_timeout(res_timeout),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Array model: restarts on arr_clr, so RUN cycle k sees ac_cyc == k. Group a pulses once, group b is a level.
    always @(posedge clk) begin
        if (arr_clr) ac_cyc <= 1;
        else         ac_cyc <= ac_cyc + 1;
    end

    always_comb begin
        arr_valid = cur.va;
        arr_done  = ((ac_cyc == cur.ca) ? cur.da : '0) | ((ac_cyc >= cur.cb) ? cur.db : '0);
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic res_t model(input tile_t t);
        res_t r;
        logic [LANES-1:0] seen;
        r.cyc = 16'd0; r.vcnt = 16'd0; r.to = 1'b0; r.lat = 2;
        if (t.mask != '0) begin
            seen = '0;
            for (int k = 1; k <= 1000; k++) begin
                seen = seen | ((k == t.ca) ? t.da : '0) | ((k >= t.cb) ? t.db : '0);
                if ((seen & t.mask) == t.mask) begin
                    r.cyc = 16'(k);
                    break;
                end
                if (t.tmo != '0 && k == int'(t.tmo)) begin
                    r.cyc = 16'(k);
                    r.to  = 1'b1;
                    break;
                end
            end
            r.vcnt = 16'(int'(r.cyc) * $countones(t.va & t.mask));
            r.lat  = int'(r.cyc) + 2;
        end
        return r;
    endfunction

    function automatic tile_t mk(input logic [LANES-1:0] mask, input logic [LANES-1:0] va,
                                 input logic [TMO_W-1:0] tmo,
                                 input logic [LANES-1:0] da, input int ca,
                                 input logic [LANES-1:0] db, input int cb);
        tile_t t;
        for (int i = 0; i < LANES*IDX_W/32; i++) t.idx[i*32 +: 32] = $urandom;
        t.mask = mask; t.va = va; t.tmo = tmo;
        t.da = da; t.ca = ca; t.db = db; t.cb = cb;
        return t;
    endfunction

    function automatic logic [LANES-1:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // All tasks start and end just after a falling edge.
    task automatic send(input tile_t t, input int exp_wait);
        int waited = 0;
        cur         = t;
        tile_idx    = t.idx;
        tile_mask   = t.mask;
        cfg_timeout = t.tmo;
        tile_valid  = 1'b1;
        exp_q.push_back(model(t));
        #1;
        while (!tile_ready && waited < 50) begin
            @(negedge clk); #1;
            waited++;
        end
        if (!tile_ready) check("accept_bound", 0, 1);
        if (exp_wait >= 0) check("accept_wait", waited, exp_wait);
        @(negedge clk);
        tile_valid = 1'b0;
        #1;
        check("clr_pulse", arr_clr, 1);
        check("clr_idx", arr_index_vector == t.idx, 1);
        check("clr_ready", tile_ready, 0);
        check("clr_busy", busy, 1);
    endtask

    task automatic collect(input int hold, input bit b2b, input tile_t nxt);
        res_t e;
        int   lat = 1;
        while (!res_valid && lat < 400) begin
            @(negedge clk); #1;
            lat++;
        end
        if (!res_valid) begin
            check("result_bound", 0, 1);
            void'(exp_q.pop_front());
            return;
        end
        e = exp_q[0];
        check("latency", lat, e.lat);
        for (int h = 0; h < hold; h++) begin
            if (b2b && h == 0) begin
                tile_idx    = nxt.idx;
                tile_mask   = nxt.mask;
                cfg_timeout = nxt.tmo;
                tile_valid  = 1'b1;
            end
            @(negedge clk); #1;
            check("hold_valid", res_valid, 1);
            check("hold_cycles", res_cycles, e.cyc);
            check("hold_ready", tile_ready, 0);
        end
        res_ready = 1'b1;
        e = exp_q.pop_front();
        check("res_cycles", res_cycles, e.cyc);
        check("res_vcnt", res_vcnt, e.vcnt);
        check("res_timeout", res_timeout, e.to);
        @(negedge clk);
        res_ready = 1'b0;
        #1;
        check("post_valid", res_valid, 0);
        check("post_busy", busy, 0);
        check("post_ready", tile_ready, 1);
    endtask

    initial begin
        logic [LANES-1:0] ones = '1;
        logic [LANES-1:0] no7;
        logic [LANES-1:0] lo;
        tile_t t, t2;
        no7 = ones; no7[7] = 1'b0;
        lo  = {{64{1'b0}}, {64{1'b1}}};
        cur = mk('0, '0, '0, '0, 0, '0, 100000);
        rstn = 1'b1; tile_valid = 1'b0; res_ready = 1'b0;
        tile_idx = '0; tile_mask = '0; cfg_timeout = '0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_clr", arr_clr, 1);
        check("rst_ready", tile_ready, 0);
        rstn = 1'b0;
        @(negedge clk); #1;
        check("rst_ready_rel", tile_ready, 1);
        check("rst_clr_rel", arr_clr, 0);
        check("rst_valid", res_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_idx", arr_index_vector == '0, 1);
        check("rst_cycles", res_cycles, 0);
        check("rst_vcnt", res_vcnt, 0);
        check("rst_to", res_timeout, 0);

        // All lanes done at cycle 5 with full valid traffic.
        send(mk(ones, ones, 8'd0, '0, 0, ones, 5), -1);  collect(0, 0, t);
        // Lane 0 only; unmasked valids and never-done lanes ignored.
        send(mk(128'h1, ones, 8'd0, '0, 0, 128'h1, 3), -1);  collect(0, 0, t);
        // Timeout at 4 with lane 7 stuck, then lane 7 finishing exactly at 4.
        send(mk(ones, rnd128(), 8'd4, '0, 0, no7, 1), -1);  collect(1, 0, t);
        send(mk(ones, rnd128(), 8'd4, 128'h80, 4, no7, 1), -1);  collect(0, 0, t);
        // Empty mask goes straight to RESULT.
        send(mk('0, ones, 8'd0, '0, 0, ones, 1), -1);  collect(0, 0, t);
        // Pulsed done on half the lanes must stick until the other half arrives.
        send(mk(ones, rnd128(), 8'd0, lo, 2, ~lo, 6), -1);  collect(0, 0, t);
        // Timeout larger than completion, and timeout of 1.
        send(mk(rnd128() | 128'h1, rnd128(), 8'd20, '0, 0, ones, 9), -1);  collect(0, 0, t);
        send(mk(ones, rnd128(), 8'd1, '0, 0, ones, 50), -1);  collect(0, 0, t);
        // Stalled result then a back-to-back single-cycle tile.
        t  = mk(rnd128() | 128'h4, rnd128(), 8'd0, '0, 0, ones, 3);
        t2 = mk(ones, rnd128(), 8'd0, '0, 0, ones, 1);
        send(t, -1);  collect(10, 1, t2);
        send(t2, 0);  collect(0, 0, t);
        // Reset in the middle of a long run discards the tile.
        send(mk(ones, ones, 8'd0, '0, 0, ones, 100), -1);
        repeat (5) @(negedge clk);
        rstn = 1'b1;
        #1;
        check("mid_rst_clr", arr_clr, 1);
        @(negedge clk);
        rstn = 1'b0;
        #1;
        void'(exp_q.pop_back());
        check("mid_rst_valid", res_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_idx", arr_index_vector == '0, 1);
        check("mid_rst_ready", tile_ready, 1);
        repeat (3) begin
            @(negedge clk); #1;
            check("mid_rst_quiet", res_valid, 0);
        end
        send(mk(rnd128() | 128'h100, rnd128(), 8'd0, '0, 0, ones, 4), -1);  collect(2, 0, t);

        check("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
